// File: rtl/calc_pkg.sv
// Shared definitions for the queue-calculator command driver and the calculator.
//   OP_W            opcode width
//   OP_PUSH..OP_MOD calculator opcodes, OP_BAD is the reserved opcode 7
//   IDLE..CHECK     driver state encoding
//   opIsBinary()    true for opcodes that consume two queue entries
package calc_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_PUSH = 3'd0;
    localparam logic [OP_W-1:0] OP_POP  = 3'd1;
    localparam logic [OP_W-1:0] OP_ADD  = 3'd2;
    localparam logic [OP_W-1:0] OP_MUL  = 3'd3;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd4;
    localparam logic [OP_W-1:0] OP_DIV  = 3'd5;
    localparam logic [OP_W-1:0] OP_MOD  = 3'd6;
    localparam logic [OP_W-1:0] OP_BAD  = 3'd7;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;
    localparam logic [1:0] CHECK = 2'd3;

    function automatic logic opIsBinary(input logic [OP_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_MOD);
    endfunction

endpackage

// File: rtl/calc_cmd_driver_if.sv
// Interfaces of the calculator command driver.
//   calc_host_if : host side. master = host, slave = driver.
//     load_valid/load_op/load_data/load_ready  program word append handshake
//     prog_clr/start                           program clear and run request
//     busy/done/error/err_pc/result            run status
//   calc_bus_if  : calculator side. master = driver, slave = calculator.
//     calc_rst/calc_in/calc_op/calc_apply      command outputs
//     calc_tail/calc_valid/calc_empty          calculator status
interface calc_host_if
    import calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PW    = 3
);
    logic             load_valid;
    logic [OP_W-1:0]  load_op;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             prog_clr;
    logic             start;
    logic             busy;
    logic             done;
    logic             error;
    logic [PW-1:0]    err_pc;
    logic [WIDTH-1:0] result;

    modport master (
        output load_valid, load_op, load_data, prog_clr, start,
        input  load_ready, busy, done, error, err_pc, result
    );

    modport slave (
        input  load_valid, load_op, load_data, prog_clr, start,
        output load_ready, busy, done, error, err_pc, result
    );
endinterface

interface calc_bus_if
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             calc_rst;
    logic [WIDTH-1:0] calc_in;
    logic [OP_W-1:0]  calc_op;
    logic             calc_apply;
    logic [WIDTH-1:0] calc_tail;
    logic             calc_valid;
    logic             calc_empty;

    modport master (
        output calc_rst, calc_in, calc_op, calc_apply,
        input  calc_tail, calc_valid, calc_empty
    );

    modport slave (
        input  calc_rst, calc_in, calc_op, calc_apply,
        output calc_tail, calc_valid, calc_empty
    );
endinterface

// File: rtl/calc_cmd_driver_prog_mem.sv
// calc_prog_mem: program store of DEPTH words of {op, operand}.
// One synchronous write port, one combinational read port. Contents are not
// reset so a loaded program survives runs.
//   clk      rising-edge clock
//   we_i     write enable
//   waddr_i  write index
//   wop_i    opcode to store
//   wdata_i  operand to store
//   raddr_i  read index
//   rop_o    opcode at raddr_i
//   rdata_o  operand at raddr_i
module calc_prog_mem
    import calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [OP_W-1:0]  wop_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [OP_W-1:0]  rop_o,
    output logic [WIDTH-1:0] rdata_o
);

    logic [OP_W+WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= {wop_i, wdata_i};
        end
    end

    assign {rop_o, rdata_o} = mem_q[raddr_i];

endmodule

// File: rtl/calc_cmd_driver.sv
// calc_cmd_driver: runs a host-loaded program of {op, operand} words against
// the queue calculator. A run resets the calculator, applies each word for one
// cycle and checks calc_valid afterwards; it ends with a one-cycle done pulse
// carrying either the final calculator tail or the index of the failing word.
//   clk    rising-edge clock
//   reset  synchronous active-high reset; aborts a run without done
//   host   calc_host_if.slave: program load, prog_clr, start, run status
//   bus    calc_bus_if.master: calculator command and status
// Build option CALC_DRV_PRECHECK_EN: track a shadow queue depth and refuse to
// apply a word the calculator would reject for depth reasons or opcode 7.
module calc_cmd_driver
    import calc_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PROG_DEPTH = 8,
    parameter int QUEUE_SIZE = 5
) (
    input  logic        clk,
    input  logic        reset,
    calc_host_if.slave  host,
    calc_bus_if.master  bus
);

    localparam int PW = $clog2(PROG_DEPTH);

    logic [1:0]       state_q, state_d;
    logic [PW:0]      progLen_q, progLen_d;
    logic [PW:0]      pc_q, pc_d;
    logic [PW-1:0]    errPc_q, errPc_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             calcRst_q, calcRst_d;
    logic             calcApply_q, calcApply_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [OP_W-1:0]  memOp;
    logic [WIDTH-1:0] memData;
    logic             loadReady;
    logic             loadFire;
    logic             issueBlocked;

    assign loadReady = (state_q == IDLE) && !host.start && !host.prog_clr &&
                       (progLen_q < (PW+1)'(PROG_DEPTH));
    assign loadFire  = host.load_valid && loadReady;

    calc_prog_mem #(
        .WIDTH (WIDTH),
        .DEPTH (PROG_DEPTH)
    ) uProgMem (
        .clk     (clk),
        .we_i    (loadFire),
        .waddr_i (progLen_q[PW-1:0]),
        .wop_i   (host.load_op),
        .wdata_i (host.load_data),
        .raddr_i (pc_q[PW-1:0]),
        .rop_o   (memOp),
        .rdata_o (memData)
    );

`ifdef CALC_DRV_PRECHECK_EN
    localparam int DW = $clog2(QUEUE_SIZE + 1);

    logic [DW-1:0] depth_q, depth_d;

    // Decide whether the word at pc would be rejected by the calculator.
    always_comb begin
        issueBlocked = 1'b0;
        if (state_q == ISSUE) begin
            case (memOp)
                OP_PUSH: issueBlocked = (int'(depth_q) >= QUEUE_SIZE);
                OP_POP:  issueBlocked = (depth_q == '0);
                OP_BAD:  issueBlocked = 1'b1;
                default: issueBlocked = (int'(depth_q) < 2);
            endcase
        end
    end

    // Shadow depth follows what the calculator queue does for each applied word.
    always_comb begin
        depth_d = depth_q;
        if (state_q == CLEAR) begin
            depth_d = '0;
        end else if ((state_q == ISSUE) && !issueBlocked) begin
            if (memOp == OP_PUSH) begin
                depth_d = depth_q + DW'(1);
            end else if ((memOp == OP_POP) || opIsBinary(memOp)) begin
                depth_d = depth_q - DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end
`else
    assign issueBlocked = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        progLen_d   = progLen_q;
        pc_d        = pc_q;
        errPc_d     = errPc_q;
        done_d      = 1'b0;
        error_d     = error_q;
        result_d    = result_q;
        calcRst_d   = calcRst_q;
        calcApply_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (host.prog_clr) begin
                    progLen_d = '0;
                end else if (host.start) begin
                    if (progLen_q == '0) begin
                        done_d  = 1'b1;
                        error_d = 1'b1;
                        errPc_d = '0;
                    end else begin
                        state_d   = CLEAR;
                        pc_d      = '0;
                        calcRst_d = 1'b1;
                    end
                end else if (loadFire) begin
                    progLen_d = progLen_q + (PW+1)'(1);
                end
            end
            CLEAR: begin
                state_d     = ISSUE;
                calcRst_d   = 1'b0;
                calcApply_d = 1'b1;
            end
            ISSUE: begin
                if (issueBlocked) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                    errPc_d = pc_q[PW-1:0];
                end else begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!bus.calc_valid) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                    errPc_d = pc_q[PW-1:0];
                end else if (pc_q == progLen_q - (PW+1)'(1)) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    error_d  = 1'b0;
                    result_d = bus.calc_tail;
                end else begin
                    state_d     = ISSUE;
                    pc_d        = pc_q + (PW+1)'(1);
                    calcApply_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            progLen_q   <= '0;
            pc_q        <= '0;
            errPc_q     <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            result_q    <= '0;
            calcRst_q   <= 1'b1;
            calcApply_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            progLen_q   <= progLen_d;
            pc_q        <= pc_d;
            errPc_q     <= errPc_d;
            done_q      <= done_d;
            error_q     <= error_d;
            result_q    <= result_d;
            calcRst_q   <= calcRst_d;
            calcApply_q <= calcApply_d;
        end
    end

    assign host.load_ready = loadReady;
    assign host.busy       = (state_q != IDLE);
    assign host.done       = done_q;
    assign host.error      = error_q;
    assign host.err_pc     = errPc_q;
    assign host.result     = result_q;

    // A word refused by the precheck must never reach the calculator.
    assign bus.calc_rst    = calcRst_q;
    assign bus.calc_in     = memData;
    assign bus.calc_op     = memOp;
    assign bus.calc_apply  = calcApply_q && !issueBlocked;

endmodule

// File: tb/tb_calc_cmd_driver.sv
// Testbench for calc_cmd_driver. Includes a behavioural queue calculator on the
// bus side, a program-level reference model that predicts each run's outcome,
// and a scoreboard monitor that checks every done pulse against the prediction.
module tb_calc_cmd_driver;
    import calc_pkg::*;

    localparam int WIDTH      = 8;
    localparam int PROG_DEPTH = 8;
    localparam int QUEUE_SIZE = 5;
    localparam int PW         = 3;

    typedef struct {
        bit err;
        int errPc;
        int res;
        int doneEdge;
        int applies;
        int applyBase;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    calc_host_if #(.WIDTH(WIDTH), .PW(PW)) host ();
    calc_bus_if  #(.WIDTH(WIDTH))          bus ();

    calc_cmd_driver #(
        .WIDTH      (WIDTH),
        .PROG_DEPTH (PROG_DEPTH),
        .QUEUE_SIZE (QUEUE_SIZE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .host  (host),
        .bus   (bus)
    );

    int   compared   = 0;
    int   mismatched = 0;
    int   edgeCnt    = 0;
    int   applyCnt   = 0;
    exp_t sbQ[$];

    int progLen;
    int progOps  [PROG_DEPTH];
    int progData [PROG_DEPTH];

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Behavioural queue calculator: tail is the newest entry, binary ops use
    // tail as the left operand and the entry below it as the right operand.
    logic [WIDTH-1:0] stk [8];
    int cnt   = 0;
    bit okBit = 1'b1;
    int xv, yv, rv;

    always @(posedge clk) begin
        if (bus.calc_rst) begin
            cnt   = 0;
            okBit = 1'b1;
        end else if (bus.calc_apply && okBit) begin
            case (bus.calc_op)
                OP_PUSH: begin
                    if (cnt >= QUEUE_SIZE) okBit = 1'b0;
                    else begin
                        stk[cnt] = bus.calc_in;
                        cnt++;
                    end
                end
                OP_POP: begin
                    if (cnt == 0) okBit = 1'b0;
                    else cnt--;
                end
                OP_ADD, OP_MUL, OP_SUB, OP_DIV, OP_MOD: begin
                    if (cnt < 2) okBit = 1'b0;
                    else begin
                        xv = int'(stk[cnt-1]);
                        yv = int'(stk[cnt-2]);
                        if ((bus.calc_op == OP_DIV || bus.calc_op == OP_MOD) && yv == 0) begin
                            okBit = 1'b0;
                        end else begin
                            case (bus.calc_op)
                                OP_ADD:  rv = xv + yv;
                                OP_MUL:  rv = xv * yv;
                                OP_SUB:  rv = xv - yv;
                                OP_DIV:  rv = xv / yv;
                                default: rv = xv % yv;
                            endcase
                            stk[cnt-2] = 8'(rv);
                            cnt--;
                        end
                    end
                end
                default: okBit = 1'b0;
            endcase
        end
        bus.calc_valid <= okBit;
        bus.calc_tail  <= (cnt > 0) ? stk[cnt-1] : '0;
        bus.calc_empty <= (cnt == 0);
    end

    // Predict a run of the current program from the opcode rules alone.
    function automatic exp_t refModel(input int base, input int applyBase);
        exp_t e;
        int   q[$];
        int   a, b, r, op;
        bit   bad;
        e.err       = 1'b0;
        e.errPc     = 0;
        e.res       = 0;
        e.applies   = 0;
        e.applyBase = applyBase;
        e.doneEdge  = base;
        if (progLen == 0) begin
            e.err = 1'b1;
            return e;
        end
        for (int k = 0; k < progLen; k++) begin
            op  = progOps[k];
            bad = 1'b0;
`ifdef CALC_DRV_PRECHECK_EN
            if (op == 7 || (op == 0 && q.size() >= QUEUE_SIZE) ||
                (op == 1 && q.size() == 0) || (op >= 2 && q.size() < 2)) begin
                e.err      = 1'b1;
                e.errPc    = k;
                e.applies  = k;
                e.doneEdge = base + 2*k + 2;
                return e;
            end
`endif
            e.applies = k + 1;
            if (op == 0) begin
                if (q.size() >= QUEUE_SIZE) bad = 1'b1;
                else q.push_back(progData[k]);
            end else if (op == 1) begin
                if (q.size() == 0) bad = 1'b1;
                else void'(q.pop_back());
            end else if (op >= 2 && op <= 6) begin
                if (q.size() < 2) bad = 1'b1;
                else begin
                    a = q.pop_back();
                    b = q.pop_back();
                    if ((op == 5 || op == 6) && b == 0) bad = 1'b1;
                    else begin
                        case (op)
                            2:       r = a + b;
                            3:       r = a * b;
                            4:       r = a - b;
                            5:       r = a / b;
                            default: r = a % b;
                        endcase
                        q.push_back(r & 255);
                    end
                end
            end else begin
                bad = 1'b1;
            end
            if (bad) begin
                e.err      = 1'b1;
                e.errPc    = k;
                e.doneEdge = base + 2*k + 3;
                return e;
            end
        end
        e.res      = (q.size() > 0) ? q[q.size()-1] : 0;
        e.doneEdge = base + 2*progLen + 1;
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (bus.calc_apply) applyCnt++;
        if (host.done) begin
            if (sbQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_done: got done=1, required no done pulse");
            end else begin
                e = sbQ.pop_front();
                checkOutput("error", int'(host.error), int'(e.err));
                if (e.err) checkOutput("err_pc", int'(host.err_pc), e.errPc);
                else       checkOutput("result", int'(host.result), e.res);
                checkOutput("done_cycle", edgeCnt, e.doneEdge);
                checkOutput("apply_count", applyCnt - e.applyBase, e.applies);
            end
        end
    end

    task automatic setWord(input int k, input int op, input int data);
        progOps[k]  = op;
        progData[k] = data;
    endtask

    task automatic clearProgram();
        host.prog_clr = 1'b1;
        @(negedge clk);
        host.prog_clr = 1'b0;
        #1;
        checkOutput("load_ready_after_clr", int'(host.load_ready), 1);
        @(negedge clk);
    endtask

    task automatic loadWords();
        for (int k = 0; k < progLen; k++) begin
            host.load_valid = 1'b1;
            host.load_op    = 3'(progOps[k]);
            host.load_data  = 8'(progData[k]);
            #1;
            checkOutput("load_ready", int'(host.load_ready), 1);
            @(negedge clk);
        end
        host.load_valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 300 && sbQ.size() > 0; i++) @(negedge clk);
        if (sbQ.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL done_timeout: got no done after 300 cycles, required done");
            sbQ.delete();
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input bit reload);
        if (reload) begin
            clearProgram();
            loadWords();
        end
        host.start = 1'b1;
        sbQ.push_back(refModel(edgeCnt + 1, applyCnt));
        @(negedge clk);
        host.start = 1'b0;
        waitDrain();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sel;
        reset           = 1'b1;
        host.load_valid = 1'b0;
        host.load_op    = '0;
        host.load_data  = '0;
        host.prog_clr   = 1'b0;
        host.start      = 1'b0;
        progLen         = 0;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy",       int'(host.busy),       0);
        checkOutput("reset_done",       int'(host.done),       0);
        checkOutput("reset_error",      int'(host.error),      0);
        checkOutput("reset_err_pc",     int'(host.err_pc),     0);
        checkOutput("reset_result",     int'(host.result),     0);
        checkOutput("reset_calc_apply", int'(bus.calc_apply),  0);
        checkOutput("reset_calc_rst",   int'(bus.calc_rst),    1);
        reset = 1'b0;
        #1;
        checkOutput("reset_load_ready", int'(host.load_ready), 1);
        @(negedge clk);

        $display("[TB] push 6, push 3, add; then rerun");
        progLen = 3;
        setWord(0, OP_PUSH, 6); setWord(1, OP_PUSH, 3); setWord(2, OP_ADD, 0);
        applyStimulus(1);
        applyStimulus(0);

        $display("[TB] push 7, push 2, sub");
        setWord(0, OP_PUSH, 7); setWord(1, OP_PUSH, 2); setWord(2, OP_SUB, 0);
        applyStimulus(1);

        $display("[TB] push 0, push 5, div");
        setWord(0, OP_PUSH, 0); setWord(1, OP_PUSH, 5); setWord(2, OP_DIV, 0);
        applyStimulus(1);

        $display("[TB] pop on empty queue");
        progLen = 1;
        setWord(0, OP_POP, 0);
        applyStimulus(1);

        $display("[TB] reserved opcode");
        progLen = 2;
        setWord(0, OP_PUSH, 1); setWord(1, OP_BAD, 0);
        applyStimulus(1);

        $display("[TB] six pushes");
        progLen = 6;
        for (int k = 0; k < 6; k++) setWord(k, OP_PUSH, k + 1);
        applyStimulus(1);

        $display("[TB] full program memory");
        progLen = 8;
        for (int k = 0; k < 8; k++) setWord(k, OP_PUSH, 10 + k);
        clearProgram();
        loadWords();
        #1;
        checkOutput("load_ready_full", int'(host.load_ready), 0);
        @(negedge clk);
        applyStimulus(0);
        clearProgram();

        $display("[TB] reset during ISSUE");
        progLen = 1;
        setWord(0, OP_PUSH, 1);
        loadWords();
        host.start = 1'b1;
        @(negedge clk);
        host.start = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("issue_busy",  int'(host.busy),      1);
        checkOutput("issue_apply", int'(bus.calc_apply), 1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("abort_busy",     int'(host.busy),      0);
        checkOutput("abort_apply",    int'(bus.calc_apply), 0);
        checkOutput("abort_calc_rst", int'(bus.calc_rst),   1);
        checkOutput("abort_done",     int'(host.done),      0);
        reset = 1'b0;
        @(negedge clk);
        progLen = 0;
        applyStimulus(0);

        $display("[TB] random programs");
        for (int r = 0; r < 25; r++) begin
            progLen = $urandom_range(1, PROG_DEPTH);
            for (int k = 0; k < progLen; k++) begin
                sel = $urandom_range(0, 9);
                if (sel < 4)       progOps[k] = 0;
                else if (sel == 4) progOps[k] = 1;
                else if (sel == 9) progOps[k] = 7;
                else               progOps[k] = $urandom_range(2, 6);
                progData[k] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
            end
            applyStimulus(1);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
